fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the pipelined core; successor to the single-cycle PC/InstMem path.
- Owns the PC and issues fetch requests over a valid/ready handshake to an instruction memory with variable, in-order latency.
- Buffers returned instructions in a FETCH_DEPTH-entry queue feeding decode, and handles stall (decode backpressure) and redirect (branch/jump from execute) by dropping stale responses.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 44 ++++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, constants and fetch-entry type for the instruction fetch front end
package fetch_pkg;
    localparam int DEF_XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [ILEN-1:0]     inst;
        logic [DEF_XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear; reads 0 when empty, accepts push on full when popping
module fetch_fifo import fetch_pkg::*; #(
    parameter int W = 32,
    parameter int D = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [W-1:0]      din,
    output logic [W-1:0]      dout,
    output logic              full,
    output logic              empty,
    output logic [$clog2(D):0] count
);
    localparam int AW = $clog2(D);
    logic [W-1:0] mem [D];
    logic [AW-1:0] rd, wr;
    logic do_push, do_pop;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || pop);
    assign full = count == (AW+1)'(D);
    assign empty = count == '0;
    assign dout = empty ? '0 : mem[rd];
    // pointers and occupancy; clear empties the FIFO in one cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else if (clear) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            wr <= wr + AW'(do_push);
            rd <= rd + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    // storage is not reset; empty masks stale contents on dout
    always_ff @(posedge clk)
        if (do_push && !clear) mem[wr] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing credit-limited fetches and queueing responses for decode; FETCH_PERF_EN adds perf counters
module fetch_unit import fetch_pkg::*; #(
    parameter int               XLEN = DEF_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = DEF_RESET_PC,
    parameter int               FETCH_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_drop_count,
    output logic [31:0]     perf_redirects,
`endif
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    localparam int CW = $clog2(FETCH_DEPTH) + 1;
    logic [XLEN-1:0] pc, tag_pc;
    logic [CW-1:0] outstanding, drop_cnt, q_count, tag_count;
    logic req_fire, dropping, rsp_live, id_fire;
    logic q_full, q_empty, tag_full, tag_empty;
    logic [2*XLEN-1:0] q_dout;
    logic unused_ok;
    assign imem_req_valid = !rst && !redirect_valid && (({1'b0, outstanding} + {1'b0, q_count}) < (CW+1)'(FETCH_DEPTH));
    assign imem_req_addr = pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign dropping = redirect_valid || drop_cnt != '0;
    assign rsp_live = imem_rsp_valid && !dropping;
    assign id_valid = !q_empty;
    assign id_fire = id_valid && id_ready;
    assign {id_inst, id_pc} = q_dout;
    assign unused_ok = ^{tag_full, tag_count, q_full, redirect_pc[1:0]};

    fetch_fifo #(.W(XLEN), .D(FETCH_DEPTH)) u_tag (
        .clk(clk), .rst(rst), .clear(redirect_valid), .push(req_fire), .pop(rsp_live),
        .din(pc), .dout(tag_pc), .full(tag_full), .empty(tag_empty), .count(tag_count)
    );

    fetch_fifo #(.W(2*XLEN), .D(FETCH_DEPTH)) u_queue (
        .clk(clk), .rst(rst), .clear(redirect_valid), .push(rsp_live), .pop(id_fire),
        .din({imem_rsp_data, tag_pc}), .dout(q_dout), .full(q_full), .empty(q_empty), .count(q_count)
    );

    // PC, in-flight request count and number of stale responses still to discard
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc <= {RESET_PC[XLEN-1:2], 2'b00};
            outstanding <= '0;
            drop_cnt <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc <= {redirect_pc[XLEN-1:2], 2'b00};
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) pc <= pc + XLEN'(4);
                if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            end
        end

    rsp_needs_req: assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid && outstanding == '0));
    live_rsp_has_tag: assert property (@(posedge clk) disable iff (rst) !(rsp_live && tag_empty));

`ifdef FETCH_PERF_EN
    // saturating stall, discarded-response and redirect counters
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_drop_count <= '0;
            perf_redirects <= '0;
        end else begin
            if (id_valid && !id_ready && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (imem_rsp_valid && dropping && perf_drop_count != '1) perf_drop_count <= perf_drop_count + 32'd1;
            if (redirect_valid && perf_redirects != '1) perf_redirects <= perf_redirects + 32'd1;
        end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven and randomized checks of fetch_unit against a queue-based reference model
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic id_valid, id_ready = 1'b0;
    logic [31:0] id_inst, id_pc;
    logic redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cycles, perf_drop_count, perf_redirects;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h100), .FETCH_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
`ifdef FETCH_PERF_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_drop_count(perf_drop_count), .perf_redirects(perf_redirects),
`endif
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct { logic [31:0] pc; bit stale; } out_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct {
        bit rdy; bit idr; bit redir; logic [31:0] rpc; int lat;
        bit e_req; logic [31:0] e_addr; bit e_idv; logic [31:0] e_pc;
    } vec_t;

    out_t outq[$];
    ent_t fq[$];
    mreq_t memq[$];
    vec_t tbl[$];
    logic [31:0] m_pc = 32'h100;
    int cyc = 0, lat = 1, last_due = 0;
    int checks = 0, errors = 0;
    bit s_req, s_idv;
    logic [31:0] s_addr, s_pc;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    function automatic vec_t v(input bit rdy, input bit idr, input bit redir, input logic [31:0] rpc, input int l,
                               input bit e_req, input logic [31:0] e_addr, input bit e_idv, input logic [31:0] e_pc);
        vec_t r;
        r.rdy = rdy; r.idr = idr; r.redir = redir; r.rpc = rpc; r.lat = l;
        r.e_req = e_req; r.e_addr = e_addr; r.e_idv = e_idv; r.e_pc = e_pc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_id_valid", {31'b0, id_valid}, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_inst", id_inst, 32'h0);
        memq.delete();
        outq.delete();
        fq.delete();
        m_pc = 32'h100;
        last_due = cyc;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input bit rdy, input bit idr, input bit redir, input logic [31:0] rpc);
        bit rv, e_req, e_idv;
        logic [31:0] ep, ei;
        out_t o;
        int d;
        @(negedge clk);
        imem_req_ready = rdy;
        id_ready = idr;
        redirect_valid = redir;
        redirect_pc = rpc;
        rv = 1'b0;
        imem_rsp_data = 32'h0;
        if (memq.size() > 0) if (memq[0].due <= cyc) begin
            rv = 1'b1;
            imem_rsp_data = inst_of(memq[0].addr);
        end
        imem_rsp_valid = rv;
        #1;
        e_req = !redir && (outq.size() + fq.size() < 4);
        e_idv = fq.size() > 0;
        ep = 32'h0;
        ei = 32'h0;
        if (e_idv) begin
            ep = fq[0].pc;
            ei = fq[0].inst;
        end
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
        if (e_req) check("req_addr", imem_req_addr, m_pc);
        check("id_valid", {31'b0, id_valid}, {31'b0, e_idv});
        check("id_pc", id_pc, ep);
        check("id_inst", id_inst, ei);
        s_req = imem_req_valid;
        s_addr = imem_req_addr;
        s_idv = id_valid;
        s_pc = id_pc;
        @(posedge clk);
        if (rv) void'(memq.pop_front());
        if (s_req && rdy) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            memq.push_back('{s_addr, d});
        end
        if (e_idv && idr) void'(fq.pop_front());
        if (rv && outq.size() > 0) begin
            o = outq.pop_front();
            if (!redir && !o.stale) fq.push_back('{inst_of(o.pc), o.pc});
        end
        if (redir) begin
            fq.delete();
            foreach (outq[i]) outq[i].stale = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
        end else if (e_req && rdy) begin
            outq.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        cyc++;
    endtask

    initial begin
        tbl.push_back(v(1,1,0,0,1, 1,32'h100, 0,0));
        tbl.push_back(v(1,1,0,0,1, 1,32'h104, 0,0));
        tbl.push_back(v(1,1,0,0,1, 1,32'h108, 1,32'h100));
        tbl.push_back(v(1,1,0,0,1, 1,32'h10c, 1,32'h104));
        tbl.push_back(v(1,0,0,0,1, 1,32'h110, 1,32'h108));
        tbl.push_back(v(1,0,0,0,1, 1,32'h114, 1,32'h108));
        tbl.push_back(v(1,0,0,0,1, 0,0, 1,32'h108));
        tbl.push_back(v(1,0,0,0,1, 0,0, 1,32'h108));
        tbl.push_back(v(1,1,0,0,1, 0,0, 1,32'h108));
        tbl.push_back(v(1,0,0,0,1, 1,32'h118, 1,32'h10c));
        tbl.push_back(v(1,0,0,0,1, 0,0, 1,32'h10c));
        tbl.push_back(v(1,0,0,0,1, 0,0, 1,32'h10c));
        tbl.push_back(v(1,1,0,0,3, 0,0, 1,32'h10c));
        tbl.push_back(v(1,1,0,0,3, 1,32'h11c, 1,32'h110));
        tbl.push_back(v(1,1,0,0,3, 1,32'h120, 1,32'h114));
        tbl.push_back(v(1,1,1,32'h203,3, 0,0, 1,32'h118));
        tbl.push_back(v(1,1,0,0,3, 1,32'h200, 0,0));
        tbl.push_back(v(1,1,0,0,3, 1,32'h204, 0,0));
        tbl.push_back(v(1,1,0,0,3, 1,32'h208, 0,0));
        tbl.push_back(v(1,1,0,0,3, 1,32'h20c, 0,0));
        tbl.push_back(v(1,1,0,0,3, 0,0, 1,32'h200));
        tbl.push_back(v(1,1,0,0,3, 1,32'h210, 1,32'h204));

`ifdef FETCH_PERF_EN
        do_reset();
        lat = 3;
        for (int i = 0; i < 12; i++) step(1, 0, i == 2, 32'h200);
        #1;
        check("perf_stall_cycles", perf_stall_cycles, 32'd5);
        check("perf_drop_count", perf_drop_count, 32'd2);
        check("perf_redirects", perf_redirects, 32'd1);
`endif

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            lat = tbl[i].lat;
            step(tbl[i].rdy, tbl[i].idr, tbl[i].redir, tbl[i].rpc);
            check($sformatf("tbl%0d_req", i), {31'b0, s_req}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req) check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_idv", i), {31'b0, s_idv}, {31'b0, tbl[i].e_idv});
            if (tbl[i].e_idv) check($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
        end

        do_reset();
        lat = 1;
        repeat (3) step(1, 1, 0, 0);
        step(1, 1, 1, 32'h200);
        check("redir_rsp_req_blocked", {31'b0, s_req}, 32'h0);
        step(1, 1, 0, 0);
        check("redir_rsp_next_req", {31'b0, s_req}, 32'h1);
        check("redir_rsp_next_addr", s_addr, 32'h200);
        check("redir_rsp_flushed", {31'b0, s_idv}, 32'h0);
        step(1, 1, 0, 0);
        check("redir_rsp_wait", {31'b0, s_idv}, 32'h0);
        step(1, 1, 0, 0);
        check("redir_rsp_first_idv", {31'b0, s_idv}, 32'h1);
        check("redir_rsp_first_pc", s_pc, 32'h200);

        do_reset();
        lat = 1;
        repeat (4) step(1, 0, 0, 0);
        check("pre_reset_idv", {31'b0, s_idv}, 32'h1);
        do_reset();
        step(1, 1, 0, 0);
        check("restart_req", {31'b0, s_req}, 32'h1);
        check("restart_addr", s_addr, 32'h100);

        for (int i = 0; i < 800; i++) begin
            logic [31:0] rpc;
            if ($urandom_range(0, 249) == 0) do_reset();
            lat = $urandom_range(1, 4);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 14) == 0, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
